serv_axi_rd_arb: RTL and testbench
==================================

# serv_axi_rd_arb

Two-to-one AXI4 read-channel arbiter on the SERV read paths. It merges the instruction-fetch read master (port 0, from the Wishbone-to-AXI read bridge) and the data-bus read channel (port 1, from the Wishbone-to-AXI read/write bridge) into one AXI4 read master. That master drives a single-ported memory or interconnect slave port. One transaction is outstanding at a time, and R beats are routed back to the granted requester.

## Interface
Parameters:
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 32, R data width
- ID_WIDTH, 4, AR/R ID width, forwarded unchanged

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- S{0,1}_AXI_arid  in  ID_WIDTH  requester read ID
- S{0,1}_AXI_araddr  in  ADDR_WIDTH  requester read address
- S{0,1}_AXI_arlen  in  8  burst length minus one
- S{0,1}_AXI_arsize  in  3  beat size
- S{0,1}_AXI_arburst  in  2  burst type
- S{0,1}_AXI_arvalid  in  1  AR valid
- S{0,1}_AXI_arready  out  1  AR accept
- S{0,1}_AXI_rid / rdata / rresp / rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  routed R payload
- S{0,1}_AXI_rvalid  out  1  routed R valid
- S{0,1}_AXI_rready  in  1  requester R ready
- M_AXI_arid / araddr / arlen / arsize / arburst  out  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  registered AR payload
- M_AXI_arvalid  out  1  AR valid to memory side
- M_AXI_arready  in  1  memory-side AR accept
- M_AXI_rid / rdata / rresp / rlast / rvalid  in  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1  memory-side R channel
- M_AXI_rready  out  1  R ready to memory side
- o_len_err  out  1  sticky flag: rlast beat count mismatched arlen

## Operation
- FSM states:
  - IDLE → ADDR on accept of any S arvalid.
  - ADDR → DATA on M_AXI_arvalid & M_AXI_arready.
  - DATA → IDLE on M_AXI_rvalid & M_AXI_rready & M_AXI_rlast.
- Grant is evaluated only in IDLE. The winner's S_arready is asserted combinationally in that same cycle. The loser's arready stays 0, and its request stays pending (AXI requires arvalid held).
- On accept: latch grant index and AR payload into holding registers. M_AXI_ar* comes only from these registers, never passes through combinationally.
- DATA routing:
  - S_g rvalid/rdata/rresp/rlast/rid = M_AXI_r*.
  - M_AXI_rready = S_g rready.
  - Non-granted S rvalid = 0; its rdata/rid/rresp/rlast are driven 0.
- R beats arriving outside DATA are not acknowledged: M_AXI_rready = 0 in IDLE/ADDR.
- Beat counter (8-bit) is cleared on accept and increments per R handshake.
  - On rlast handshake with count != latched arlen: set o_len_err.
  - On any R handshake with count == arlen but rlast = 0: also set o_len_err.
  - The FSM still exits only on rlast.
- o_len_err clears only on ARESET.
- Reset (any state, including mid-burst): state IDLE, grant history = port 0 preferred next, counter 0, o_len_err 0.
  - Outputs: M_AXI_arvalid 0, M_AXI_ar* payload 0, M_AXI_rready 0, all S arready/rvalid 0, S r* payload 0.
  - The in-flight burst is abandoned; nothing further is forwarded.

## Timing
- Accept at cycle T (IDLE) → M_AXI_arvalid = 1 at T+1. Address latency is one cycle.
- M_AXI_arvalid stays high with a stable payload until M_AXI_arready; ready may arrive in the same cycle arvalid rises.
- R path is zero-latency combinational in DATA; throughput is one beat per cycle.
- A rlast handshake at cycle N returns the FSM to IDLE at N+1. The earliest next accept is N+1, so back-to-back transactions are spaced by 2 cycles of overhead.
- Simultaneous arvalid on both ports in IDLE is resolved per Configuration. A port whose arvalid rises while the FSM is busy waits; it is never dropped.

## Configuration
- SERV_AXI_RD_ARB_RR_EN undefined:
  - Fixed priority, port 1 (data) wins ties, so loads are not starved by fetch.
  - Grant history register is not built.
- SERV_AXI_RD_ARB_RR_EN defined:
  - Round-robin. A 1-bit last-grant register updates on each accept.
  - On a tie, the port not granted last wins; after reset, port 0 wins the first tie.
  - A lone requester always wins regardless of history.

## Structure
- Package serv_axi_pkg holds:
  - FSM state enum (IDLE, ADDR, DATA)
  - grant index localparams (GNT_IBUS = 0, GNT_DBUS = 1)
  - AXI constants BURST_INCR = 2'b01 and RESP_OKAY = 2'b00
- One sub-module: serv_axi_arb_grant, a combinational pick from two request bits plus last-grant. It holds the SERV_AXI_RD_ARB_RR_EN split so the FSM is identical in both builds.

## Test plan
- Port 0 alone, araddr 0x100, arlen 0, arready held 1 → M_AXI_arvalid at T+1 with araddr 0x100; one beat 0xDEADBEEF delivered on S0 only; S1_AXI_rvalid stays 0.
- Both ports request in the same cycle (S0 0x0, S1 0x2000), fixed build → S1 granted first. Round-robin build after reset → S0 first, then S1, then alternation over 4 repeated ties.
- S1 arlen 3, memory returns 4 beats with M_AXI_arready and rready stalls inserted → 4 beats in order; S0 request raised mid-burst accepted only the cycle after rlast.
- Memory asserts rlast on beat 2 of an arlen 3 burst → o_len_err = 1, FSM returns to IDLE; next transaction proceeds normally; flag stays 1 until ARESET.
- ARESET asserted in DATA after beat 1 of 4 → all valids 0 next cycle, M_AXI_rready 0, o_len_err 0; a new S0 request after release is granted normally.

Source files
------------

// File: rtl/serv_axi_pkg.sv
// Shared types and constants for the SERV two-to-one AXI4 read arbiter.
package serv_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic GNT_IBUS = 1'b0;
  localparam logic GNT_DBUS = 1'b1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/serv_axi_arb_grant.sv
// Two-requester grant pick. SERV_AXI_RD_ARB_RR_EN selects round-robin with a
// last-grant history bit; otherwise fixed priority with the data port winning ties.
module serv_axi_arb_grant
  import serv_axi_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_gnt
);

`ifdef SERV_AXI_RD_ARB_RR_EN
  logic r_last_gnt;

  // Tie goes to the port not granted last; a lone requester always wins.
  always_comb begin
    o_gnt = GNT_IBUS;
    if (i_req == 2'b11) begin
      o_gnt = ~r_last_gnt;
    end else if (i_req[1]) begin
      o_gnt = GNT_DBUS;
    end else begin
      o_gnt = GNT_IBUS;
    end
  end

  // Reset to the data port so the instruction port wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_gnt <= GNT_DBUS;
    end else if (i_accept) begin
      r_last_gnt <= o_gnt;
    end
  end
`else
  logic w_unused;

  assign w_unused = i_clk ^ i_rst ^ i_accept ^ i_req[0];

  // Data port wins every tie so loads are never held off by fetch.
  always_comb begin
    o_gnt = GNT_IBUS;
    if (i_req[1]) begin
      o_gnt = GNT_DBUS;
    end else begin
      o_gnt = GNT_IBUS;
    end
  end
`endif

endmodule

// File: rtl/serv_axi_rd_arb.sv
// Two-to-one AXI4 read arbiter: instruction fetch (S0) and data bus (S1) onto one
// read master, one transaction outstanding. Tie policy set by SERV_AXI_RD_ARB_RR_EN.
module serv_axi_rd_arb
  import serv_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ID_WIDTH-1:0]   S0_AXI_arid,
  input  logic [ADDR_WIDTH-1:0] S0_AXI_araddr,
  input  logic [7:0]            S0_AXI_arlen,
  input  logic [2:0]            S0_AXI_arsize,
  input  logic [1:0]            S0_AXI_arburst,
  input  logic                  S0_AXI_arvalid,
  output logic                  S0_AXI_arready,
  output logic [ID_WIDTH-1:0]   S0_AXI_rid,
  output logic [DATA_WIDTH-1:0] S0_AXI_rdata,
  output logic [1:0]            S0_AXI_rresp,
  output logic                  S0_AXI_rlast,
  output logic                  S0_AXI_rvalid,
  input  logic                  S0_AXI_rready,
  input  logic [ID_WIDTH-1:0]   S1_AXI_arid,
  input  logic [ADDR_WIDTH-1:0] S1_AXI_araddr,
  input  logic [7:0]            S1_AXI_arlen,
  input  logic [2:0]            S1_AXI_arsize,
  input  logic [1:0]            S1_AXI_arburst,
  input  logic                  S1_AXI_arvalid,
  output logic                  S1_AXI_arready,
  output logic [ID_WIDTH-1:0]   S1_AXI_rid,
  output logic [DATA_WIDTH-1:0] S1_AXI_rdata,
  output logic [1:0]            S1_AXI_rresp,
  output logic                  S1_AXI_rlast,
  output logic                  S1_AXI_rvalid,
  input  logic                  S1_AXI_rready,
  output logic [ID_WIDTH-1:0]   M_AXI_arid,
  output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [7:0]            M_AXI_arlen,
  output logic [2:0]            M_AXI_arsize,
  output logic [1:0]            M_AXI_arburst,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [ID_WIDTH-1:0]   M_AXI_rid,
  input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic                  M_AXI_rlast,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready,
  output logic                  o_len_err
);

  arb_state_e            r_state;
  logic                  r_gnt;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  r_arvalid;
  logic [7:0]            r_cnt;
  logic                  r_len_err;

  logic [1:0] w_req;
  logic       w_pick;
  logic       w_accept;
  logic       w_in_data;
  logic       w_route0;
  logic       w_route1;
  logic       w_rhs;

  assign w_req    = {S1_AXI_arvalid, S0_AXI_arvalid};
  assign w_accept = (r_state == IDLE) && (w_req != 2'b00);

  serv_axi_arb_grant u_grant (
    .i_clk    (ACLK),
    .i_rst    (ARESET),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt    (w_pick)
  );

  assign S0_AXI_arready = w_accept && (w_pick == GNT_IBUS);
  assign S1_AXI_arready = w_accept && (w_pick == GNT_DBUS);

  assign M_AXI_arid    = r_arid;
  assign M_AXI_araddr  = r_araddr;
  assign M_AXI_arlen   = r_arlen;
  assign M_AXI_arsize  = r_arsize;
  assign M_AXI_arburst = r_arburst;
  assign M_AXI_arvalid = r_arvalid;
  assign o_len_err     = r_len_err;

  // R channel is a zero-latency passthrough to the granted port, only in DATA.
  assign w_in_data    = (r_state == DATA);
  assign w_route0     = w_in_data && (r_gnt == GNT_IBUS);
  assign w_route1     = w_in_data && (r_gnt == GNT_DBUS);
  assign M_AXI_rready = (w_route0 && S0_AXI_rready) || (w_route1 && S1_AXI_rready);
  assign w_rhs        = M_AXI_rvalid && M_AXI_rready;

  assign S0_AXI_rvalid = w_route0 && M_AXI_rvalid;
  assign S0_AXI_rdata  = w_route0 ? M_AXI_rdata : {DATA_WIDTH{1'b0}};
  assign S0_AXI_rid    = w_route0 ? M_AXI_rid   : {ID_WIDTH{1'b0}};
  assign S0_AXI_rresp  = w_route0 ? M_AXI_rresp : 2'b00;
  assign S0_AXI_rlast  = w_route0 && M_AXI_rlast;

  assign S1_AXI_rvalid = w_route1 && M_AXI_rvalid;
  assign S1_AXI_rdata  = w_route1 ? M_AXI_rdata : {DATA_WIDTH{1'b0}};
  assign S1_AXI_rid    = w_route1 ? M_AXI_rid   : {ID_WIDTH{1'b0}};
  assign S1_AXI_rresp  = w_route1 ? M_AXI_rresp : 2'b00;
  assign S1_AXI_rlast  = w_route1 && M_AXI_rlast;

  // Transaction FSM with AR holding registers, beat counter and sticky length error.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_IBUS;
      r_arid    <= {ID_WIDTH{1'b0}};
      r_araddr  <= {ADDR_WIDTH{1'b0}};
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
      r_arburst <= 2'b00;
      r_arvalid <= 1'b0;
      r_cnt     <= 8'd0;
      r_len_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_gnt     <= w_pick;
            r_arid    <= w_pick ? S1_AXI_arid    : S0_AXI_arid;
            r_araddr  <= w_pick ? S1_AXI_araddr  : S0_AXI_araddr;
            r_arlen   <= w_pick ? S1_AXI_arlen   : S0_AXI_arlen;
            r_arsize  <= w_pick ? S1_AXI_arsize  : S0_AXI_arsize;
            r_arburst <= w_pick ? S1_AXI_arburst : S0_AXI_arburst;
            r_arvalid <= 1'b1;
            r_cnt     <= 8'd0;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (M_AXI_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_rhs) begin
            r_cnt <= r_cnt + 8'd1;
            // Early rlast, or a missing rlast on the expected final beat.
            if (M_AXI_rlast && (r_cnt != r_arlen)) begin
              r_len_err <= 1'b1;
            end
            if (!M_AXI_rlast && (r_cnt == r_arlen)) begin
              r_len_err <= 1'b1;
            end
            if (M_AXI_rlast) begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_arvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_axi_rd_arb.sv
// Directed bench for serv_axi_rd_arb; R beats are checked through a scoreboard queue.
module tb_serv_axi_rd_arb;
  import serv_axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S0_AXI_arid, S1_AXI_arid;
  logic [31:0] S0_AXI_araddr, S1_AXI_araddr;
  logic [7:0]  S0_AXI_arlen, S1_AXI_arlen;
  logic [2:0]  S0_AXI_arsize, S1_AXI_arsize;
  logic [1:0]  S0_AXI_arburst, S1_AXI_arburst;
  logic        S0_AXI_arvalid, S1_AXI_arvalid;
  logic        S0_AXI_arready, S1_AXI_arready;
  logic [3:0]  S0_AXI_rid, S1_AXI_rid;
  logic [31:0] S0_AXI_rdata, S1_AXI_rdata;
  logic [1:0]  S0_AXI_rresp, S1_AXI_rresp;
  logic        S0_AXI_rlast, S1_AXI_rlast;
  logic        S0_AXI_rvalid, S1_AXI_rvalid;
  logic        S0_AXI_rready, S1_AXI_rready;
  logic [3:0]  M_AXI_arid;
  logic [31:0] M_AXI_araddr;
  logic [7:0]  M_AXI_arlen;
  logic [2:0]  M_AXI_arsize;
  logic [1:0]  M_AXI_arburst;
  logic        M_AXI_arvalid, M_AXI_arready;
  logic [3:0]  M_AXI_rid;
  logic [31:0] M_AXI_rdata;
  logic [1:0]  M_AXI_rresp;
  logic        M_AXI_rlast, M_AXI_rvalid, M_AXI_rready;
  logic        o_len_err;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 ACLK = ~ACLK;

  serv_axi_rd_arb dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S0_AXI_arid(S0_AXI_arid), .S0_AXI_araddr(S0_AXI_araddr), .S0_AXI_arlen(S0_AXI_arlen),
    .S0_AXI_arsize(S0_AXI_arsize), .S0_AXI_arburst(S0_AXI_arburst),
    .S0_AXI_arvalid(S0_AXI_arvalid), .S0_AXI_arready(S0_AXI_arready),
    .S0_AXI_rid(S0_AXI_rid), .S0_AXI_rdata(S0_AXI_rdata), .S0_AXI_rresp(S0_AXI_rresp),
    .S0_AXI_rlast(S0_AXI_rlast), .S0_AXI_rvalid(S0_AXI_rvalid), .S0_AXI_rready(S0_AXI_rready),
    .S1_AXI_arid(S1_AXI_arid), .S1_AXI_araddr(S1_AXI_araddr), .S1_AXI_arlen(S1_AXI_arlen),
    .S1_AXI_arsize(S1_AXI_arsize), .S1_AXI_arburst(S1_AXI_arburst),
    .S1_AXI_arvalid(S1_AXI_arvalid), .S1_AXI_arready(S1_AXI_arready),
    .S1_AXI_rid(S1_AXI_rid), .S1_AXI_rdata(S1_AXI_rdata), .S1_AXI_rresp(S1_AXI_rresp),
    .S1_AXI_rlast(S1_AXI_rlast), .S1_AXI_rvalid(S1_AXI_rvalid), .S1_AXI_rready(S1_AXI_rready),
    .M_AXI_arid(M_AXI_arid), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen),
    .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready),
    .o_len_err(o_len_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every R handshake on an S port must match the next expected beat.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S0_AXI_rvalid && S1_AXI_rvalid) check("dual_rvalid", 1'b1, 1'b0);
      if ((S0_AXI_rvalid && S0_AXI_rready) || (S1_AXI_rvalid && S1_AXI_rready)) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("r_port", S1_AXI_rvalid, e.port);
          check("r_data", S1_AXI_rvalid ? S1_AXI_rdata : S0_AXI_rdata, e.data);
          check("r_last", S1_AXI_rvalid ? S1_AXI_rlast : S0_AXI_rlast, e.last);
          check("r_id",   S1_AXI_rvalid ? S1_AXI_rid   : S0_AXI_rid,   e.id);
          check("r_other_data", S1_AXI_rvalid ? S0_AXI_rdata : S1_AXI_rdata, 32'd0);
        end
      end
    end
  end

  // Present a read request and wait (bounded) for the DUT to accept it.
  task automatic issue(input logic port, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id);
    bit got = 1'b0;
    if (port) begin
      S1_AXI_arvalid = 1'b1; S1_AXI_araddr = addr; S1_AXI_arlen = len; S1_AXI_arid = id;
    end else begin
      S0_AXI_arvalid = 1'b1; S0_AXI_araddr = addr; S0_AXI_arlen = len; S0_AXI_arid = id;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      got = port ? S1_AXI_arready : S0_AXI_arready;
      if (!got) begin
        @(posedge ACLK); #1;
      end
    end
    check("ar_accept_timeout", got, 1'b1);
    @(posedge ACLK); #1;
    if (port) S1_AXI_arvalid = 1'b0;
    else S0_AXI_arvalid = 1'b0;
  endtask

  // Drive one memory-side R beat until handshake; requester rready held low for 'stall' cycles.
  task automatic mem_beat(input logic port, input logic [31:0] data, input logic last,
                          input logic [3:0] id, input int stall);
    bit done = 1'b0;
    exp_t e;
    e.port = port; e.data = data; e.last = last; e.id = id;
    sb.push_back(e);
    M_AXI_rvalid = 1'b1; M_AXI_rdata = data; M_AXI_rlast = last; M_AXI_rid = id;
    M_AXI_rresp = RESP_OKAY;
    for (int i = 0; i < 50 && !done; i++) begin
      S0_AXI_rready = (i >= stall);
      S1_AXI_rready = (i >= stall);
      @(negedge ACLK);
      done = M_AXI_rvalid && M_AXI_rready;
      @(posedge ACLK); #1;
    end
    check("beat_timeout", done, 1'b1);
    M_AXI_rvalid = 1'b0; M_AXI_rlast = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic exp_port;
    ARESET = 1'b1;
    S0_AXI_arvalid = 1'b0; S0_AXI_arid = 4'd0; S0_AXI_araddr = 32'd0; S0_AXI_arlen = 8'd0;
    S0_AXI_arsize = 3'd2; S0_AXI_arburst = BURST_INCR; S0_AXI_rready = 1'b1;
    S1_AXI_arvalid = 1'b0; S1_AXI_arid = 4'd0; S1_AXI_araddr = 32'd0; S1_AXI_arlen = 8'd0;
    S1_AXI_arsize = 3'd2; S1_AXI_arburst = BURST_INCR; S1_AXI_rready = 1'b1;
    M_AXI_arready = 1'b1; M_AXI_rid = 4'd0; M_AXI_rdata = 32'd0; M_AXI_rresp = RESP_OKAY;
    M_AXI_rlast = 1'b0; M_AXI_rvalid = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_m_arvalid", M_AXI_arvalid, 1'b0);
    check("rst_m_rready", M_AXI_rready, 1'b0);
    check("rst_m_araddr", M_AXI_araddr, 32'd0);
    check("rst_len_err", o_len_err, 1'b0);
    @(posedge ACLK); #1 ARESET = 1'b0;

    // Port 0 alone, single beat.
    issue(1'b0, 32'h100, 8'd0, 4'd3);
    @(negedge ACLK);
    check("t1_m_arvalid", M_AXI_arvalid, 1'b1);
    check("t1_m_araddr", M_AXI_araddr, 32'h100);
    check("t1_m_arid", M_AXI_arid, 4'd3);
    check("t1_m_arburst", M_AXI_arburst, BURST_INCR);
    check("t1_rready_in_addr", M_AXI_rready, 1'b0);
    @(posedge ACLK); #1;
    mem_beat(1'b0, 32'hDEADBEEF, 1'b1, 4'd3, 0);
    @(negedge ACLK);
    check("t1_idle_arvalid", M_AXI_arvalid, 1'b0);
    check("t1_s1_rvalid", S1_AXI_rvalid, 1'b0);
    @(posedge ACLK); #1;

    // Repeated ties from reset.
    do_reset();
    S0_AXI_arvalid = 1'b1; S0_AXI_araddr = 32'h0;    S0_AXI_arid = 4'd1; S0_AXI_arlen = 8'd0;
    S1_AXI_arvalid = 1'b1; S1_AXI_araddr = 32'h2000; S1_AXI_arid = 4'd2; S1_AXI_arlen = 8'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef SERV_AXI_RD_ARB_RR_EN
      exp_port = (i % 2 == 1);
`else
      exp_port = 1'b1;
`endif
      @(negedge ACLK);
      check("tie_s0_arready", S0_AXI_arready, !exp_port);
      check("tie_s1_arready", S1_AXI_arready, exp_port);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      check("tie_m_araddr", M_AXI_araddr, exp_port ? 32'h2000 : 32'h0);
      @(posedge ACLK); #1;
      mem_beat(exp_port, 32'hA000_0000 + 32'(i), 1'b1, exp_port ? 4'd2 : 4'd1, 0);
    end
    S0_AXI_arvalid = 1'b0; S1_AXI_arvalid = 1'b0;

    // Four-beat burst with AR and R stalls; S0 raised mid-burst.
    M_AXI_arready = 1'b0;
    issue(1'b1, 32'h3000, 8'd3, 4'd5);
    @(negedge ACLK);
    check("t3_m_araddr", M_AXI_araddr, 32'h3000);
    check("t3_m_arlen", M_AXI_arlen, 8'd3);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("t3_arvalid_held", M_AXI_arvalid, 1'b1);
    check("t3_araddr_held", M_AXI_araddr, 32'h3000);
    @(posedge ACLK); #1 M_AXI_arready = 1'b1;
    mem_beat(1'b1, 32'hB000_0000, 1'b0, 4'd5, 0);
    mem_beat(1'b1, 32'hB000_0001, 1'b0, 4'd5, 2);
    S0_AXI_arvalid = 1'b1; S0_AXI_araddr = 32'h400; S0_AXI_arlen = 8'd0; S0_AXI_arid = 4'd1;
    mem_beat(1'b1, 32'hB000_0002, 1'b0, 4'd5, 1);
    @(negedge ACLK);
    check("t3_s0_wait", S0_AXI_arready, 1'b0);
    @(posedge ACLK); #1;
    mem_beat(1'b1, 32'hB000_0003, 1'b1, 4'd5, 0);
    @(negedge ACLK);
    check("t3_s0_accept_after_last", S0_AXI_arready, 1'b1);
    check("t3_len_err", o_len_err, 1'b0);
    @(posedge ACLK); #1 S0_AXI_arvalid = 1'b0;
    @(negedge ACLK);
    check("t3_s0_araddr", M_AXI_araddr, 32'h400);
    @(posedge ACLK); #1;
    mem_beat(1'b0, 32'h1111_1111, 1'b1, 4'd1, 0);

    // Early rlast raises the sticky length error.
    issue(1'b1, 32'h5000, 8'd3, 4'd6);
    mem_beat(1'b1, 32'hC000_0000, 1'b0, 4'd6, 0);
    mem_beat(1'b1, 32'hC000_0001, 1'b0, 4'd6, 0);
    mem_beat(1'b1, 32'hC000_0002, 1'b1, 4'd6, 0);
    @(negedge ACLK);
    check("t4_len_err_set", o_len_err, 1'b1);
    check("t4_idle_arvalid", M_AXI_arvalid, 1'b0);
    @(posedge ACLK); #1;
    issue(1'b0, 32'h600, 8'd1, 4'd2);
    mem_beat(1'b0, 32'hD000_0000, 1'b0, 4'd2, 0);
    mem_beat(1'b0, 32'hD000_0001, 1'b1, 4'd2, 0);
    @(negedge ACLK);
    check("t4_len_err_sticky", o_len_err, 1'b1);
    @(posedge ACLK); #1;

    // Reset mid-burst abandons the transfer.
    issue(1'b1, 32'h7000, 8'd3, 4'd7);
    mem_beat(1'b1, 32'hE000_0000, 1'b0, 4'd7, 0);
    M_AXI_rvalid = 1'b1; M_AXI_rdata = 32'hE000_0001; M_AXI_rid = 4'd7;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("t5_s1_rvalid", S1_AXI_rvalid, 1'b0);
    check("t5_s0_rvalid", S0_AXI_rvalid, 1'b0);
    check("t5_s1_rdata", S1_AXI_rdata, 32'd0);
    check("t5_m_rready", M_AXI_rready, 1'b0);
    check("t5_m_arvalid", M_AXI_arvalid, 1'b0);
    check("t5_len_err", o_len_err, 1'b0);
    @(posedge ACLK); #1;
    ARESET = 1'b0; M_AXI_rvalid = 1'b0;
    sb.delete();
    issue(1'b0, 32'h800, 8'd0, 4'd4);
    @(negedge ACLK);
    check("t5_m_arvalid_after", M_AXI_arvalid, 1'b1);
    check("t5_m_araddr_after", M_AXI_araddr, 32'h800);
    @(posedge ACLK); #1;
    mem_beat(1'b0, 32'hF00D_F00D, 1'b1, 4'd4, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
